fetch_align_unit: RTL and testbench
===================================

# fetch_align_unit

Instruction-stream aligner and sequencer between the instruction-fetch port and the compressed-instruction expander. It accepts 32-bit word-aligned fetch words and tracks the instruction PC. It splits or stitches 16-bit parcels into whole instructions, handling compressed pairs and full-length instructions that straddle two words. It then presents exactly one instruction per handshake, with its PC and a compressed flag, to the decode stage.

## Interface
- XLEN, 64, PC width in bits
- RESET_PC, 64'h0000_0000_0000_1000, PC after reset (bit 0 ignored)
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_fetch_data  input  32  fetch word; sequential word addresses from last redirect, aligned down to 4
- i_fetch_valid  input  1  i_fetch_data valid
- o_fetch_ready  output  1  word accepted on i_fetch_valid & o_fetch_ready (combinational)
- i_flush  input  1  redirect request, single cycle
- i_flush_pc  input  XLEN  redirect target
- o_valid  output  1  instruction output valid
- i_ready  input  1  downstream accepts on o_valid & i_ready
- o_ins  output  32  instruction; compressed = {16'h0, parcel}
- o_pc  output  XLEN  PC of o_ins
- o_is_comp  output  1  o_ins is a 16-bit parcel

## Operation
- Full-length parcel: bits[1:0] == 2'b11. Any other value is compressed.
- State: EMPTY (no held parcel), HALF (hold_q[15:0] valid), SKIP (discard next word's low half).
- load_en = !o_valid | i_ready. The output register loads only when load_en is 1.
- EMPTY, word w:
  - w compressed: emit w[15:0] at pc; hold w[31:16]; go to HALF; pc += 2.
  - Otherwise: emit w at pc; stay in EMPTY; pc += 4.
  - o_fetch_ready = load_en.
- HALF, hold h compressed: emit h; go to EMPTY; pc += 2.
  - o_fetch_ready = 0; no word is needed.
- HALF, hold h full-length, word w: emit {w[15:0], h}; hold w[31:16]; stay in HALF; pc += 4.
  - o_fetch_ready = load_en.
- SKIP, word w: hold w[31:16]; go to HALF; emit nothing.
  - o_fetch_ready = 1, independent of load_en.
- The internal pc register always holds the PC of the next parcel to emit. o_pc is pc sampled at emit.
- PC arithmetic is modulo 2^XLEN; wrap-around is silent.
- Flush has highest priority. On flush:
  - o_fetch_ready = 0; o_valid clears next cycle; hold is discarded.
  - pc <= {i_flush_pc[XLEN-1:1], 1'b0}.
  - state <= i_flush_pc[1] ? SKIP : EMPTY.
  - A concurrent i_ready handshake still counts as consumed by downstream.
- Upstream restarts its stream at i_flush_pc & ~3 on the cycle after flush.
- Illegal encodings are passed through unchanged; detecting them is the expander's job.

## Timing
- Reset values:
  - o_valid = 0, o_ins = 0, o_is_comp = 0, o_pc = 0.
  - pc = RESET_PC & ~1; state = RESET_PC[1] ? SKIP : EMPTY; hold_q = 0.
- Latency: a word accepted in cycle n drives o_valid in cycle n+1.
- A HALF-compressed emit needs no input and also appears one cycle after the load decision.
- Throughput: one instruction per cycle when i_ready = 1, including back-to-back compressed pairs. A pair costs two cycles per fetch word.
- While o_valid & !i_ready: o_ins, o_pc and o_is_comp are held stable, and o_fetch_ready = 0 except in SKIP.
- o_valid falls only after a handshake with no new emit, or after a flush.
- If reset asserts mid-operation, all state returns to reset values immediately; the held parcel is lost.

## Configuration
- FETCH_RVC_EN defined: full behaviour above, with 2-byte parcel alignment.
- FETCH_RVC_EN undefined:
  - Every word is emitted whole with pc += 4, regardless of bits[1:0]; o_is_comp is tied to 0.
  - HALF and SKIP do not exist.
  - i_flush_pc[1:0] and RESET_PC[1:0] are treated as 0.

## Test plan
- Full-length stream: RESET_PC 0x1000; words 0x00A00093 then 0x00100113 with i_ready = 1.
  - Emits 0x00A00093@0x1000 and 0x00100113@0x1004, each one cycle after acceptance, o_is_comp = 0.
- Compressed pair: word 0x45014581.
  - Emits 0x00004581@0x1000 then 0x00004501@0x1002, both o_is_comp = 1.
  - o_fetch_ready = 0 in the second cycle.
- Straddle: words 0x00934581 then 0x45010050.
  - Emits 0x4581@0x1000, 0x00500093@0x1002 (o_is_comp = 0), 0x4501@0x1006.
- Backpressure: i_ready low for 3 cycles with o_valid = 1.
  - Outputs stay stable and o_fetch_ready = 0; the next instruction follows the cycle after i_ready rises.
- Redirect: flush to 0x2002 while in HALF, then word 0x45810001.
  - No o_valid in the cycle after flush; old hold is dropped; low half 0x0001 is skipped.
  - Emits 0x4581@0x2002.
- FETCH_RVC_EN undefined: word 0x45014581.
  - Emits a single 0x45014581 with o_is_comp = 0; next PC is +4.

Source files
------------

// File: rtl/fetch_align_unit.sv
// Instruction-stream aligner: splits/stitches 16-bit parcels from 32-bit fetch words into
// one instruction per handshake. Define FETCH_RVC_EN for compressed (2-byte) parcel support.
module fetch_align_unit #(
    parameter int               XLEN     = 64,
    parameter logic [XLEN-1:0]  RESET_PC = 64'h0000_0000_0000_1000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [31:0]      i_fetch_data,
    input  logic             i_fetch_valid,
    output logic             o_fetch_ready,
    input  logic             i_flush,
    input  logic [XLEN-1:0]  i_flush_pc,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_ins,
    output logic [XLEN-1:0]  o_pc,
    output logic             o_is_comp
);

    localparam logic [XLEN-1:0] PC_INC4 = {{(XLEN-3){1'b0}}, 3'b100};

    logic             load_en_s;
    logic             fready_s;
    logic             emit_s;
    logic [31:0]      emit_ins_s;
    logic             emit_comp_s;
    logic [XLEN-1:0]  pc_r;
    logic [XLEN-1:0]  pc_n_s;
    logic             valid_r;
    logic [31:0]      ins_r;
    logic [XLEN-1:0]  pc_out_r;
    logic             comp_r;

`ifdef FETCH_RVC_EN
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_SKIP  = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] PC_MASK  = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [XLEN-1:0] PC_INC2  = {{(XLEN-2){1'b0}}, 2'b10};
    localparam state_t          RESET_ST = RESET_PC[1] ? ST_SKIP : ST_EMPTY;

    state_t       state_r;
    state_t       state_n_s;
    logic [15:0]  hold_r;
    logic [15:0]  hold_n_s;

    // Next-state, parcel assembly and fetch-ready decode
    always_comb begin
        load_en_s   = !valid_r || i_ready;
        fready_s    = 1'b0;
        emit_s      = 1'b0;
        emit_ins_s  = 32'h0000_0000;
        emit_comp_s = 1'b0;
        pc_n_s      = pc_r;
        state_n_s   = state_r;
        hold_n_s    = hold_r;
        if (i_flush) begin
            pc_n_s    = i_flush_pc & PC_MASK;
            state_n_s = i_flush_pc[1] ? ST_SKIP : ST_EMPTY;
            hold_n_s  = 16'h0000;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    fready_s = load_en_s;
                    if (i_fetch_valid && load_en_s) begin
                        emit_s = 1'b1;
                        if (i_fetch_data[1:0] != 2'b11) begin
                            emit_ins_s  = {16'h0000, i_fetch_data[15:0]};
                            emit_comp_s = 1'b1;
                            hold_n_s    = i_fetch_data[31:16];
                            state_n_s   = ST_HALF;
                            pc_n_s      = pc_r + PC_INC2;
                        end else begin
                            emit_ins_s = i_fetch_data;
                            pc_n_s     = pc_r + PC_INC4;
                        end
                    end else begin
                        emit_s = 1'b0;
                    end
                end
                ST_HALF: begin
                    // A held compressed parcel drains without consuming a word
                    if (hold_r[1:0] != 2'b11) begin
                        fready_s = 1'b0;
                        if (load_en_s) begin
                            emit_s      = 1'b1;
                            emit_ins_s  = {16'h0000, hold_r};
                            emit_comp_s = 1'b1;
                            state_n_s   = ST_EMPTY;
                            pc_n_s      = pc_r + PC_INC2;
                        end else begin
                            emit_s = 1'b0;
                        end
                    end else begin
                        fready_s = load_en_s;
                        if (i_fetch_valid && load_en_s) begin
                            emit_s     = 1'b1;
                            emit_ins_s = {i_fetch_data[15:0], hold_r};
                            hold_n_s   = i_fetch_data[31:16];
                            pc_n_s     = pc_r + PC_INC4;
                        end else begin
                            emit_s = 1'b0;
                        end
                    end
                end
                ST_SKIP: begin
                    fready_s = 1'b1;
                    if (i_fetch_valid) begin
                        hold_n_s  = i_fetch_data[31:16];
                        state_n_s = ST_HALF;
                    end else begin
                        state_n_s = ST_SKIP;
                    end
                end
                default: begin
                    state_n_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Alignment state and held upper parcel
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= RESET_ST;
            hold_r  <= 16'h0000;
        end else begin
            state_r <= state_n_s;
            hold_r  <= hold_n_s;
        end
    end
`else
    localparam logic [XLEN-1:0] PC_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    // Whole-word pass-through with word-aligned PC
    always_comb begin
        load_en_s   = !valid_r || i_ready;
        fready_s    = 1'b0;
        emit_s      = 1'b0;
        emit_ins_s  = 32'h0000_0000;
        emit_comp_s = 1'b0;
        pc_n_s      = pc_r;
        if (i_flush) begin
            pc_n_s = i_flush_pc & PC_MASK;
        end else begin
            fready_s = load_en_s;
            if (i_fetch_valid && load_en_s) begin
                emit_s     = 1'b1;
                emit_ins_s = i_fetch_data;
                pc_n_s     = pc_r + PC_INC4;
            end else begin
                emit_s = 1'b0;
            end
        end
    end
`endif

    // PC of the next parcel to emit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_r <= RESET_PC & PC_MASK;
        end else begin
            pc_r <= pc_n_s;
        end
    end

    // Output register: loads only when empty or being consumed; flush drops valid
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_r  <= 1'b0;
            ins_r    <= 32'h0000_0000;
            pc_out_r <= {XLEN{1'b0}};
            comp_r   <= 1'b0;
        end else if (i_flush) begin
            valid_r <= 1'b0;
        end else if (load_en_s) begin
            valid_r <= emit_s;
            if (emit_s) begin
                ins_r    <= emit_ins_s;
                pc_out_r <= pc_r;
                comp_r   <= emit_comp_s;
            end
        end
    end

    assign o_fetch_ready = fready_s;
    assign o_valid       = valid_r;
    assign o_ins         = ins_r;
    assign o_pc          = pc_out_r;
    assign o_is_comp     = comp_r;

endmodule

// File: tb/tb_fetch_align_unit.sv
// Self-checking bench for fetch_align_unit: directed vector table, async reset sequence and a
// randomized stream checked against a memory-decode reference model. Honors FETCH_RVC_EN.
module tb_fetch_align_unit;

`ifdef FETCH_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif
    localparam int          N    = 48;
    localparam logic [63:0] BASE = 64'h0000_0000_0008_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] fetch_data;
    logic        fetch_valid;
    logic        fetch_ready;
    logic        flush;
    logic [63:0] flush_pc;
    logic        valid;
    logic        ready;
    logic [31:0] ins;
    logic [63:0] pc;
    logic        is_comp;

    int checks   = 0;
    int failures = 0;

    fetch_align_unit dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_fetch_data  (fetch_data),
        .i_fetch_valid (fetch_valid),
        .o_fetch_ready (fetch_ready),
        .i_flush       (flush),
        .i_flush_pc    (flush_pc),
        .o_valid       (valid),
        .i_ready       (ready),
        .o_ins         (ins),
        .o_pc          (pc),
        .o_is_comp     (is_comp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic [63:0] fpc;
        logic        fv;
        logic [31:0] fd;
        logic        rdy;
        logic        ev;
        logic [31:0] eins;
        logic [63:0] epc;
        logic        ec;
        logic        efr;
    } vec_t;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] pc;
        logic        comp;
    } exp_t;

    vec_t        vt[$];
    exp_t        q[$];
    int          qi;
    logic [31:0] mem[N];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic void row(logic fl, logic [63:0] fpc, logic fv, logic [31:0] fd, logic rdy,
                                logic ev, logic [31:0] eins, logic [63:0] epc, logic ec, logic efr);
        vec_t v;
        v.fl = fl; v.fpc = fpc; v.fv = fv; v.fd = fd; v.rdy = rdy;
        v.ev = ev; v.eins = eins; v.epc = epc; v.ec = ec; v.efr = efr;
        vt.push_back(v);
    endfunction

    // Reference: 16-bit parcel at byte offset o within the test memory
    function automatic logic [15:0] parcel(int o);
        logic [31:0] w;
        w = mem[o >> 2];
        return ((o & 2) != 0) ? w[31:16] : w[15:0];
    endfunction

    // Reference: decode the instruction sequence starting at byte offset off
    function automatic void build(int off);
        int          o;
        logic [15:0] p;
        exp_t        e;
        q.delete();
        qi = 0;
        o = RVC ? (off & ~1) : (off & ~3);
        forever begin
            if (RVC) begin
                if (o + 2 > 4 * N) break;
                p = parcel(o);
                if (p[1:0] != 2'b11) begin
                    e.ins = {16'h0000, p}; e.pc = BASE + 64'(o); e.comp = 1'b1;
                    q.push_back(e);
                    o += 2;
                end else begin
                    if (o + 4 > 4 * N) break;
                    e.ins = {parcel(o + 2), p}; e.pc = BASE + 64'(o); e.comp = 1'b0;
                    q.push_back(e);
                    o += 4;
                end
            end else begin
                if (o + 4 > 4 * N) break;
                e.ins = mem[o >> 2]; e.pc = BASE + 64'(o); e.comp = 1'b0;
                q.push_back(e);
                o += 4;
            end
        end
    endfunction

    task automatic idle_inputs();
        flush = 1'b0; flush_pc = 64'h0; fetch_valid = 1'b0; fetch_data = 32'h0; ready = 1'b1;
    endtask

    initial begin
        int          off;
        int          wi;
        logic        do_flush;
        logic        prev_stall;
        logic [31:0] prev_ins;
        logic [63:0] prev_pc;
        logic        prev_comp;

`ifdef FETCH_RVC_EN
        row(0, 0, 1, 32'h00A00093, 1, 0, 0, 0, 0, 1);
        row(0, 0, 1, 32'h00100113, 1, 1, 32'h00A00093, 64'h1000, 0, 1);
        row(0, 0, 0, 0, 1, 1, 32'h00100113, 64'h1004, 0, 1);
        row(1, 64'h1000, 0, 0, 1, 0, 0, 0, 0, 0);
        row(0, 0, 1, 32'h45014581, 1, 0, 0, 0, 0, 1);
        row(0, 0, 0, 0, 1, 1, 32'h00004581, 64'h1000, 1, 0);
        row(0, 0, 0, 0, 1, 1, 32'h00004501, 64'h1002, 1, 1);
        row(1, 64'h1000, 0, 0, 1, 0, 0, 0, 0, 0);
        row(0, 0, 1, 32'h00934581, 1, 0, 0, 0, 0, 1);
        row(0, 0, 1, 32'h45010050, 1, 1, 32'h00004581, 64'h1000, 1, 1);
        row(0, 0, 0, 0, 1, 1, 32'h00500093, 64'h1002, 0, 0);
        row(0, 0, 0, 0, 1, 1, 32'h00004501, 64'h1006, 1, 1);
        row(1, 64'h1000, 0, 0, 1, 0, 0, 0, 0, 0);
        row(0, 0, 1, 32'h00A00093, 1, 0, 0, 0, 0, 1);
        row(0, 0, 1, 32'h00100113, 0, 1, 32'h00A00093, 64'h1000, 0, 0);
        row(0, 0, 1, 32'h00100113, 0, 1, 32'h00A00093, 64'h1000, 0, 0);
        row(0, 0, 1, 32'h00100113, 0, 1, 32'h00A00093, 64'h1000, 0, 0);
        row(0, 0, 1, 32'h00100113, 1, 1, 32'h00A00093, 64'h1000, 0, 1);
        row(0, 0, 0, 0, 1, 1, 32'h00100113, 64'h1004, 0, 1);
        row(1, 64'h1000, 0, 0, 1, 0, 0, 0, 0, 0);
        row(0, 0, 1, 32'h00934581, 1, 0, 0, 0, 0, 1);
        row(1, 64'h2002, 1, 32'h12345678, 1, 1, 32'h00004581, 64'h1000, 1, 0);
        row(0, 0, 1, 32'h45810001, 1, 0, 0, 0, 0, 1);
        row(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        row(0, 0, 0, 0, 1, 1, 32'h00004581, 64'h2002, 1, 1);
        row(1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 1, 0, 0, 0, 0, 0);
        row(0, 0, 1, 32'h00930000, 1, 0, 0, 0, 0, 1);
        row(0, 0, 1, 32'h45010050, 1, 0, 0, 0, 0, 1);
        row(0, 0, 0, 0, 1, 1, 32'h00500093, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
        row(0, 0, 0, 0, 1, 1, 32'h00004501, 64'h0000_0000_0000_0002, 1, 1);
`else
        row(0, 0, 1, 32'h45014581, 1, 0, 0, 0, 0, 1);
        row(0, 0, 1, 32'h00A00093, 1, 1, 32'h45014581, 64'h1000, 0, 1);
        row(0, 0, 0, 0, 1, 1, 32'h00A00093, 64'h1004, 0, 1);
        row(1, 64'h2002, 0, 0, 1, 0, 0, 0, 0, 0);
        row(0, 0, 1, 32'h45810001, 1, 0, 0, 0, 0, 1);
        row(0, 0, 0, 0, 0, 1, 32'h45810001, 64'h2000, 0, 0);
        row(0, 0, 1, 32'h11111111, 0, 1, 32'h45810001, 64'h2000, 0, 0);
        row(0, 0, 1, 32'h11111111, 1, 1, 32'h45810001, 64'h2000, 0, 1);
        row(0, 0, 0, 0, 1, 1, 32'h11111111, 64'h2004, 0, 1);
        row(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        row(1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 1, 0, 0, 0, 0, 0);
        row(0, 0, 1, 32'hAAAA0003, 1, 0, 0, 0, 0, 1);
        row(0, 0, 1, 32'hBBBB0003, 1, 1, 32'hAAAA0003, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1);
        row(0, 0, 0, 0, 1, 1, 32'hBBBB0003, 64'h0, 0, 1);
`endif

        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 64'(valid), 64'h0);
        chk("reset_ins", 64'(ins), 64'h0);
        chk("reset_pc", pc, 64'h0);
        chk("reset_comp", 64'(is_comp), 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            @(posedge clk);
            #1;
            flush = vt[i].fl; flush_pc = vt[i].fpc; fetch_valid = vt[i].fv;
            fetch_data = vt[i].fd; ready = vt[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 64'(valid), 64'(vt[i].ev));
            chk($sformatf("vec%0d_fready", i), 64'(fetch_ready), 64'(vt[i].efr));
            if (vt[i].ev) begin
                chk($sformatf("vec%0d_ins", i), 64'(ins), 64'(vt[i].eins));
                chk($sformatf("vec%0d_pc", i), pc, vt[i].epc);
                chk($sformatf("vec%0d_comp", i), 64'(is_comp), 64'(vt[i].ec));
            end
        end

        // Asynchronous reset in the middle of a stalled emit drops everything
        @(posedge clk); #1;
        idle_inputs(); flush = 1'b1; flush_pc = 64'h1000;
        @(posedge clk); #1;
        idle_inputs(); fetch_valid = 1'b1; fetch_data = 32'h00934581; ready = 1'b0;
        @(posedge clk); #1;
        fetch_valid = 1'b0;
        @(negedge clk);
        chk("prerst_valid", 64'(valid), 64'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(valid), 64'h0);
        chk("midrst_ins", 64'(ins), 64'h0);
        chk("midrst_pc", pc, 64'h0);
        chk("midrst_comp", 64'(is_comp), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        idle_inputs(); fetch_valid = 1'b1; fetch_data = 32'h00A00093;
        @(negedge clk);
        chk("postrst_fready", 64'(fetch_ready), 64'h1);
        @(posedge clk); #1;
        fetch_valid = 1'b0;
        @(negedge clk);
        chk("postrst_valid", 64'(valid), 64'h1);
        chk("postrst_ins", 64'(ins), 64'h00A00093);
        chk("postrst_pc", pc, 64'h1000);
        chk("postrst_comp", 64'(is_comp), 64'h0);

        // Randomized stream against the memory-decode model
        for (int i = 0; i < N; i++) begin
            mem[i] = $urandom;
            if ($urandom_range(0, 1) == 0) mem[i][1:0] = 2'b11;
            if ($urandom_range(0, 1) == 0) mem[i][17:16] = 2'b11;
        end
        @(posedge clk); #1;
        idle_inputs(); flush = 1'b1;
        off = $urandom_range(0, 4 * N - 1);
        flush_pc = BASE + 64'(off);
        build(off);
        wi = off >> 2;
        prev_stall = 1'b0;
        prev_ins = 32'h0; prev_pc = 64'h0; prev_comp = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            do_flush = (c < 2600) && ($urandom_range(0, 39) == 0);
            flush = do_flush;
            if (do_flush) begin
                off = $urandom_range(0, 4 * N - 1);
                flush_pc = BASE + 64'(off);
            end
            fetch_valid = (wi < N) && ($urandom_range(0, 3) != 0);
            fetch_data = (wi < N) ? mem[wi] : 32'h0;
            ready = (c >= 2600) || ($urandom_range(0, 9) < 7);
            @(negedge clk);
            if (prev_stall) begin
                chk("stall_valid", 64'(valid), 64'h1);
                chk("stall_ins", 64'(ins), 64'(prev_ins));
                chk("stall_pc", pc, prev_pc);
                chk("stall_comp", 64'(is_comp), 64'(prev_comp));
            end
            if (valid && !ready) chk("stall_fready", 64'(fetch_ready), 64'h0);
            if (valid && ready) begin
                if (qi < q.size()) begin
                    chk("rand_ins", 64'(ins), 64'(q[qi].ins));
                    chk("rand_pc", pc, q[qi].pc);
                    chk("rand_comp", 64'(is_comp), 64'(q[qi].comp));
                end else begin
                    chk("rand_extra_emit", 64'(qi), 64'(q.size()));
                end
                qi++;
            end
            prev_stall = valid && !ready && !flush;
            prev_ins = ins; prev_pc = pc; prev_comp = is_comp;
            if (fetch_valid && fetch_ready) wi++;
            if (do_flush) begin
                build(off);
                wi = off >> 2;
            end
        end
        chk("rand_drain", 64'(qi), 64'(q.size()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
